// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one 16-bit carry-select slice reused NUM_WORDS times.
// Optional macro WIDE_ADD_SIGNED_OVF_EN adds a registered signed-overflow flag.
module carry_select_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, A[7:0]} + {1'b0, B[7:0]} + {8'd0, cin};
  // upper byte precomputed for both carries, picked by the low carry
  assign hi0 = {1'b0, A[15:8]} + {1'b0, B[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign S[7:0] = lo[7:0];
  assign {cout, S[15:8]} = lo[8] ? hi1 : hi0;
endmodule

module wide_add_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] a,
  input  logic [WORD_W*NUM_WORDS-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] sum,
  output logic                        cout,
  output logic                        busy
`ifdef WIDE_ADD_SIGNED_OVF_EN
  ,
  output logic                        ovf
`endif
);
  localparam int W     = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int OFS_W = IDX_W + 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFS_W-1:0]  ofs;
  logic [WORD_W-1:0] s_slice;
  logic              c_slice;
  logic              accept;
  logic              run;
  logic              last;

  assign ofs = {idx_q, 4'b0000};

  carry_select_adder u_csa (
    .A    (a_q[ofs +: WORD_W]),
    .B    (b_q[ofs +: WORD_W]),
    .cin  (carry_q),
    .S    (s_slice),
    .cout (c_slice)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        idx_q   <= '0;
      end
      if (run) begin
        sum_q[ofs +: WORD_W] <= s_slice;
        carry_q              <= c_slice;
        idx_q <= last ? '0 : idx_q + IDX_W'(1);
        if (last) cout_q <= c_slice;
      end
    end
  end

`ifdef WIDE_ADD_SIGNED_OVF_EN
  logic ovf_q;

  // s_slice[WORD_W-1] is the final sum MSB on the last run cycle
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (run && last)
      ovf_q <= (a_q[W-1] ~^ b_q[W-1]) &
               (s_slice[WORD_W-1] ^ a_q[W-1]);
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (NUM_WORDS=4, 64-bit).
// Directed vectors; a monitor pops expected results on each handshake.
module tb_wide_add_sequencer;
  localparam int N = 4;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef WIDE_ADD_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  wide_add_sequencer #(.NUM_WORDS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef WIDE_ADD_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [W:0] act,
                     input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {v, s};
  endfunction

  // Monitor: compare on every result handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", sum);
      end else begin
        e = exp_q.pop_front();
        chk("result", {cout, sum}, e[W:0]);
        chk("in_ready_done", {{W{1'b0}}, in_ready}, '0);
`ifdef WIDE_ADD_SIGNED_OVF_EN
        chk("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, e[W+1]});
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input int hold, input bit chk_lat);
    logic [W+1:0] e;
    int k;
    bit seen;
    e = model(x, y, c);
    out_ready = (hold == 0);
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int t = 1; t <= 20 && !seen; t++) begin
      @(posedge clk);
      #1;
      k = t;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no out_valid expected within 20");
      void'(exp_q.pop_back());
      return;
    end
    if (chk_lat) chk("latency", W'(k), W'(N));
    for (int h = 0; h < hold; h++) begin
      chk("hold_sum", {cout, sum}, e[W:0]);
      chk("hold_flags", {{(W-1){1'b0}}, out_valid, in_ready}, {{(W-1){1'b0}}, 2'b10});
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_release", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_flags", {{(W-2){1'b0}}, in_ready, out_valid, busy},
        {{(W-2){1'b0}}, 3'b100});
    chk("reset_sum", {cout, sum}, '0);

    do_op(64'h0, 64'h0, 1'b0, 0, 1'b1);
    do_op(64'h0, 64'h0, 1'b1, 0, 1'b1);
    do_op('1, '1, 1'b1, 0, 1'b1);
    do_op('1, '1, 1'b0, 0, 1'b1);
    do_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);

    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10, 1'b1);
    do_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0, 1'b1);

    // abandon an operation part way through
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'h1111_1111_1111_1111;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrun_flags", {{(W-2){1'b0}}, in_ready, out_valid, busy},
        {{(W-2){1'b0}}, 3'b100});
    chk("midrun_sum", {cout, sum}, '0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrun_no_result", {{W{1'b0}}, out_valid}, '0);
    do_op(64'hDEAD_BEEF_0000_FFFF, 64'h2152_4111_FFFF_0001, 1'b1, 0, 1'b1);

    for (int i = 1; i < 200; i += 6)
      for (int j = 0; j <= 375; j += 3)
        do_op(W'(i + j), W'(i * j), 1'((i + j) & 1), 0, 1'b0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
